// File: rtl/lsu_mem_ctrl_if.sv
// ============================================================================
// lsu_mem_ctrl_if : execute-stage request and data-memory bus bundle (rev 1.0)
// ============================================================================
`default_nettype none

interface lsu_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  enable_mem;
  logic                  is_load;
  logic                  is_store;
  logic [ADDR_WIDTH-1:0] alu_result;
  logic                  alu_overflow;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  mem_done;
  logic                  mem_fault;
  logic                  stall;

  // Environment side: pipeline plus memory.
  modport master (
    output enable_mem, is_load, is_store, alu_result, alu_overflow, store_data,
    output mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  load_data, load_valid, mem_done, mem_fault, stall
  );

  // Load/store unit side.
  modport slave (
    input  enable_mem, is_load, is_store, alu_result, alu_overflow, store_data,
    input  mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output load_data, load_valid, mem_done, mem_fault, stall
  );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// lsu_mem_ctrl : load/store unit running one req/ack data-memory transaction
// rev 1.0
// ============================================================================
`default_nettype none

module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  lsu_mem_ctrl_if.slave bus
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_ld_data;
  logic                  r_ld_valid;
  logic                  r_done;
  logic                  r_fault;
  logic                  r_stall;

  logic w_bad_op;
  logic w_bad_addr;

  assign w_bad_op   = (bus.is_load == bus.is_store);
  assign w_bad_addr = bus.alu_overflow | (|bus.alu_result[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable_mem) begin
            if (w_bad_op || w_bad_addr) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_done  <= 1'b1;
              r_stall <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_we    <= bus.is_store;
              r_addr  <= bus.alu_result;
              r_wdata <= bus.store_data;
              r_stall <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // An ack arriving on the timeout edge still completes the access.
          if (bus.mem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_stall <= 1'b0;
            r_done  <= 1'b1;
            if (!r_we) begin
              r_ld_data  <= bus.mem_rdata;
              r_ld_valid <= 1'b1;
            end
          end else if (r_cnt == c_CNT_LAST) begin
            r_state <= S_FAULT;
            r_req   <= 1'b0;
            r_fault <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_FAULT: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = r_req;
  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.load_data  = r_ld_data;
  assign bus.load_valid = r_ld_valid;
  assign bus.mem_done   = r_done;
  assign bus.mem_fault  = r_fault;
  assign bus.stall      = r_stall;

endmodule

`default_nettype wire
